// File: rtl/qspi_slave_rx.sv
// QSPI slave receiver: serial header (command, length, address) on MOSI,
// optional dummy edges, then multi-lane data packed little-endian into words.
// Everything runs in the QSPI_CLK domain; chip select high is the reset.
module qspi_slave_rx #(
    parameter int CMD_BITS     = 1,
    parameter int LEN_BITS     = 10,
    parameter int ADDR_BITS    = 32,
    parameter int DUMMY_CYCLES = 3,
    parameter int DATA_LANES   = 4,
    parameter int WORD_BYTES   = 2,
    parameter int LEN_LIMIT    = 1
) (
    input  logic                    QSPI_CLK,
    input  logic                    QSPI_CS,
    input  logic                    QSPI_MOSI,
    input  logic                    QSPI_MISO,
    input  logic                    QSPI_WP,
    input  logic                    QSPI_HD,
    output logic [CMD_BITS-1:0]     q_cmd,
    output logic [LEN_BITS-1:0]     q_length,
    output logic [ADDR_BITS-1:0]    q_address,
    output logic                    q_hdr_valid,
    output logic [WORD_BYTES*8-1:0] q_data,
    output logic                    q_data_valid,
    output logic                    q_data_last,
    output logic [LEN_BITS-1:0]     q_word_idx,
    output logic                    q_overrun,
    output logic                    q_active
);

    localparam int         WORD_W         = WORD_BYTES * 8;
    localparam int         BEATS_PER_BYTE = 8 / DATA_LANES;
    localparam int         BEATS_PER_WORD = WORD_BYTES * BEATS_PER_BYTE;
    localparam int         CNT_W          = 8;
    localparam logic [7:0] LANE_MASK      = 8'((1 << DATA_LANES) - 1);

    typedef enum logic [2:0] {S_CMD, S_LEN, S_ADDR, S_DUMMY, S_DATA, S_DONE} state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;       // edges within a header field / beats within a word
    logic [2:0]            bcnt_q, bcnt_d;     // beats within the current byte
    logic [CMD_BITS-1:0]   cmd_sr_q, cmd_sr_d;
    logic [LEN_BITS-1:0]   len_sr_q, len_sr_d;
    logic [ADDR_BITS-1:0]  addr_sr_q, addr_sr_d;
    logic [CMD_BITS-1:0]   cmd_q, cmd_d;
    logic [LEN_BITS-1:0]   len_q, len_d;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic                  hdr_valid_q, hdr_valid_d;
    logic [7:0]            byte_q, byte_d;
    logic [WORD_W-1:0]     word_q, word_d;
    logic [WORD_W-1:0]     data_q, data_d;
    logic                  data_valid_q, data_valid_d;
    logic                  last_q, last_d;
    logic [LEN_BITS-1:0]   idx_q, idx_d;       // index the next completed word will carry
    logic [LEN_BITS-1:0]   word_idx_q, word_idx_d;
    logic                  overrun_q, overrun_d;
    logic                  active_q, active_d;

    logic [7:0]            beat_bits;
    logic [7:0]            byte_shift;
    logic [WORD_W-1:0]     word_shift;
    logic [ADDR_BITS-1:0]  addr_shift;

    // Lane sampling and the shifted byte/word candidates for this edge.
    always_comb begin
        beat_bits  = {4'b0000, QSPI_HD, QSPI_WP, QSPI_MISO, QSPI_MOSI} & LANE_MASK;
        byte_shift = (byte_q << DATA_LANES) | beat_bits;
        // Completed bytes enter at the top so the first byte ends up in bits [7:0].
        word_shift = (word_q >> 8) | (WORD_W'(byte_shift) << (WORD_W - 8));
        addr_shift = (addr_sr_q << 1) | ADDR_BITS'(QSPI_MOSI);
    end

    // Next-state and output logic for the header/data sequencer.
    always_comb begin
        // NOTE: every _d starts from a default so no path leaves it unassigned (no latches).
        state_d      = state_q;
        cnt_d        = cnt_q;
        bcnt_d       = bcnt_q;
        cmd_sr_d     = cmd_sr_q;
        len_sr_d     = len_sr_q;
        addr_sr_d    = addr_sr_q;
        cmd_d        = cmd_q;
        len_d        = len_q;
        addr_d       = addr_q;
        hdr_valid_d  = 1'b0;
        byte_d       = byte_q;
        word_d       = word_q;
        data_d       = data_q;
        data_valid_d = 1'b0;
        last_d       = 1'b0;
        idx_d        = idx_q;
        word_idx_d   = word_idx_q;
        overrun_d    = overrun_q;
        active_d     = 1'b1;

        unique case (state_q)
            S_CMD: begin
                cmd_sr_d = (cmd_sr_q << 1) | CMD_BITS'(QSPI_MOSI);
                if (cnt_q == CNT_W'(CMD_BITS - 1)) begin
                    cnt_d   = '0;
                    state_d = S_LEN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_LEN: begin
                len_sr_d = (len_sr_q << 1) | LEN_BITS'(QSPI_MOSI);
                if (cnt_q == CNT_W'(LEN_BITS - 1)) begin
                    cnt_d   = '0;
                    state_d = S_ADDR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_ADDR: begin
                addr_sr_d = addr_shift;
                if (cnt_q == CNT_W'(ADDR_BITS - 1)) begin
                    cnt_d       = '0;
                    cmd_d       = cmd_sr_q;
                    len_d       = len_sr_q;
                    addr_d      = addr_shift;
                    hdr_valid_d = 1'b1;
                    state_d     = (DUMMY_CYCLES == 0) ? S_DATA : S_DUMMY;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DUMMY: begin
                if (cnt_q == CNT_W'(DUMMY_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                byte_d = byte_shift;
                if (bcnt_q == 3'(BEATS_PER_BYTE - 1)) begin
                    bcnt_d = '0;
                    word_d = word_shift;
                end else begin
                    bcnt_d = bcnt_q + 3'd1;
                end
                if (cnt_q == CNT_W'(BEATS_PER_WORD - 1)) begin
                    cnt_d        = '0;
                    data_d       = word_shift;
                    data_valid_d = 1'b1;
                    word_idx_d   = idx_q;
                    idx_d        = idx_q + LEN_BITS'(1);
                    if (LEN_LIMIT != 0 && idx_q == len_q) begin
                        last_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                overrun_d = 1'b1;
            end
            default: state_d = S_CMD;
        endcase
    end

    // State register; CS high discards any partial header or word.
    always_ff @(posedge QSPI_CLK or posedge QSPI_CS) begin
        if (QSPI_CS) begin
            state_q      <= S_CMD;
            cnt_q        <= '0;
            bcnt_q       <= '0;
            cmd_sr_q     <= '0;
            len_sr_q     <= '0;
            addr_sr_q    <= '0;
            cmd_q        <= '0;
            len_q        <= '0;
            addr_q       <= '0;
            hdr_valid_q  <= 1'b0;
            byte_q       <= '0;
            word_q       <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            last_q       <= 1'b0;
            idx_q        <= '0;
            word_idx_q   <= '0;
            overrun_q    <= 1'b0;
            active_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bcnt_q       <= bcnt_d;
            cmd_sr_q     <= cmd_sr_d;
            len_sr_q     <= len_sr_d;
            addr_sr_q    <= addr_sr_d;
            cmd_q        <= cmd_d;
            len_q        <= len_d;
            addr_q       <= addr_d;
            hdr_valid_q  <= hdr_valid_d;
            byte_q       <= byte_d;
            word_q       <= word_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            last_q       <= last_d;
            idx_q        <= idx_d;
            word_idx_q   <= word_idx_d;
            overrun_q    <= overrun_d;
            active_q     <= active_d;
        end
    end

    assign q_cmd        = cmd_q;
    assign q_length     = len_q;
    assign q_address    = addr_q;
    assign q_hdr_valid  = hdr_valid_q;
    assign q_data       = data_q;
    assign q_data_valid = data_valid_q;
    assign q_data_last  = last_q;
    assign q_word_idx   = word_idx_q;
    assign q_overrun    = overrun_q;
    assign q_active     = active_q;

endmodule
